// File: rtl/fixed_pkg.sv
// -----------------------------------------------------------------------------
// fixed_pkg
//   Shared definitions for the signed two's-complement fixed-point blocks
//   (multiplier today, adder/MAC later).
//
//   Contents:
//     FIXED_W, FIXED_FRAC : default word width and fractional bits (Q8.12)
//     round_mode_e        : rounding mode of the build, for reporting only
//     ROUND_MODE          : mode selected by the build
//     sat_max(w)          : largest signed value of a w-bit word
//     sat_min(w)          : smallest signed value of a w-bit word
//
//   Configuration macro: FIXED_MULT_ROUND_EN (round half toward +inf when
//   defined, truncate toward -inf otherwise).
// -----------------------------------------------------------------------------
package fixed_pkg;

  localparam int FIXED_W    = 20;
  localparam int FIXED_FRAC = 12;

  typedef enum logic {
    TRUNC         = 1'b0,
    ROUND_HALF_UP = 1'b1
  } round_mode_e;

`ifdef FIXED_MULT_ROUND_EN
  localparam round_mode_e ROUND_MODE = ROUND_HALF_UP;
`else
  localparam round_mode_e ROUND_MODE = TRUNC;
`endif

  // Saturation bounds are returned as 64-bit values so one function serves
  // every width up to 63 bits; callers size-cast to their own width.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage : fixed_pkg

// File: rtl/fixed_sat_round.sv
// -----------------------------------------------------------------------------
// fixed_sat_round
//   Combinational scale / round / saturate of a full-width signed product back
//   to a W-bit Q(W-FRAC).FRAC word.
//
//   Parameters:
//     W    : result width in bits (signed)
//     FRAC : fractional bits of the operands and of the result
//
//   Ports:
//     prod   in  2W  signed product of two Q(W-FRAC).FRAC operands
//     result out W   scaled, optionally rounded, saturated value
//     ovf    out 1   result was clamped to the MAX or MIN bound
//
//   Configuration macro: FIXED_MULT_ROUND_EN adds 2^(FRAC-1) before the shift
//   (round half toward +inf); without it the shift truncates toward -inf.
// -----------------------------------------------------------------------------
module fixed_sat_round
  import fixed_pkg::*;
#(
  parameter int W    = FIXED_W,
  parameter int FRAC = FIXED_FRAC
) (
  input  logic signed [2*W-1:0] prod,
  output logic        [W-1:0]   result,
  output logic                  ovf
);

  // One guard bit above the product keeps the rounding addition from
  // wrapping, so the bound comparisons below always see the true value.
  localparam int XW = 2 * W + 1;

  localparam logic signed [XW-1:0] MAX_X = XW'(sat_max(W));
  localparam logic signed [XW-1:0] MIN_X = XW'(sat_min(W));

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] biased;
  logic signed [XW-1:0] scaled;

  assign ext = XW'(prod);

`ifdef FIXED_MULT_ROUND_EN
  localparam logic signed [XW-1:0] HALF_LSB = XW'(1) <<< (FRAC - 1);
  assign biased = ext + HALF_LSB;
`else
  assign biased = ext;
`endif

  // Arithmetic shift: discarded fraction bits floor toward -inf.
  assign scaled = biased >>> FRAC;

  always_comb begin
    // NOTE: every output gets a default before the branches so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    result = scaled[W-1:0];
    ovf    = 1'b0;
    if (scaled > MAX_X) begin
      result = MAX_X[W-1:0];
      ovf    = 1'b1;
    end else if (scaled < MIN_X) begin
      result = MIN_X[W-1:0];
      ovf    = 1'b1;
    end
  end

endmodule : fixed_sat_round

// File: rtl/fixed_mult_pipe.sv
// -----------------------------------------------------------------------------
// fixed_mult_pipe
//   Three-stage pipelined signed fixed-point multiplier with a valid/ready
//   stream interface, saturation and overflow reporting.
//
//     S1: operand registers
//     S2: full 2W-bit signed product
//     S3: scale / round / saturate, registered result and ovf
//
//   The whole pipeline advances together (advance = !out_valid | out_ready);
//   bubbles are carried, not squeezed out. Latency is 3 cycles from the
//   accept edge to out_valid, throughput one result per cycle.
//
//   Parameters:
//     W    : operand/result width in bits (signed), W >= 4
//     FRAC : fractional bits, 1 <= FRAC <= W-2
//
//   Ports:
//     clk        in  1  rising-edge clock
//     rst_n      in  1  asynchronous active-low reset
//     in_valid   in  1  operand pair a/b valid
//     in_ready   out 1  operands accepted this cycle when in_valid is high
//     a          in  W  multiplicand, signed Q(W-FRAC).FRAC
//     b          in  W  multiplier, signed Q(W-FRAC).FRAC
//     out_valid  out 1  result valid
//     out_ready  in  1  downstream accepts result
//     result     out W  saturated product, signed Q(W-FRAC).FRAC
//     ovf        out 1  result was saturated (qualified by out_valid)
//     ovf_sticky out 1  OR of every ovf transferred out since last clear
//     ovf_clr    in  1  synchronous clear of ovf_sticky (a set wins)
//
//   Configuration macro: FIXED_MULT_ROUND_EN selects round half toward +inf
//   instead of truncation; latency is unchanged.
// -----------------------------------------------------------------------------
module fixed_mult_pipe
  import fixed_pkg::*;
#(
  parameter int W    = FIXED_W,
  parameter int FRAC = FIXED_FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         ovf_sticky,
  input  logic         ovf_clr
);

  logic advance;
  logic xfer_in;
  logic xfer_out;

  logic                  s1_valid;
  logic signed [W-1:0]   a_q;
  logic signed [W-1:0]   b_q;

  logic                  s2_valid;
  logic signed [2*W-1:0] prod_d;
  logic signed [2*W-1:0] prod_q;

  logic [W-1:0]          sat_result;
  logic                  sat_ovf;

  // A full output register that is not being drained freezes every stage.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Valid bits and architecturally visible outputs: reset to a clean state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: registers use non-blocking assignments so every stage samples
      // the pre-edge value of the stage before it.
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        result <= sat_result;
        ovf    <= sat_ovf;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Internal datapath registers.
  // ---------------------------------------------------------------------------
  // NOTE: operand and product registers carry no reset; their contents are
  // only ever observed behind a valid bit that is itself reset.
  always_ff @(posedge clk) begin
    if (xfer_in) begin
      a_q <= a;
      b_q <= b;
    end
    if (advance && s1_valid) begin
      prod_q <= prod_d;
    end
  end

  // Both operands sign-extended to 2W bits: MIN*MIN = 2^(2W-2) still fits.
  assign prod_d = (2 * W)'(a_q) * (2 * W)'(b_q);

  fixed_sat_round #(
    .W    (W),
    .FRAC (FRAC)
  ) u_sat_round (
    .prod   (prod_q),
    .result (sat_result),
    .ovf    (sat_ovf)
  );

  // ---------------------------------------------------------------------------
  // Sticky overflow: only results actually handed downstream count, and a
  // set in the same cycle as a clear takes priority.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (xfer_out && ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule : fixed_mult_pipe

// File: tb/tb_fixed_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_fixed_mult_pipe
//   Directed self-checking bench for fixed_mult_pipe at the default Q8.12
//   (W = 20, FRAC = 12). Expected values are hand-computed constants; the
//   rounding vectors follow FIXED_MULT_ROUND_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_fixed_mult_pipe;

  localparam int W = 20;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         ovf;
  logic         ovf_sticky;
  logic         ovf_clr;

  int checks = 0;
  int errors = 0;

  fixed_mult_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation with out_ready high: accept, then the result
  // must show up exactly 3 cycles after the accept and drain the cycle after.
  task automatic run_op(input string tag, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] exp_res,
                        input logic exp_ovf);
    out_ready = 1'b1;
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    tick();                                   // accept edge
    in_valid = 1'b0;
    check({tag, " early1"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, " early2"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " result"}, 32'(result), 32'(exp_res));
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
    tick();                                   // transfer-out edge
    check({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [W-1:0] held;
  int           idx;
  int           rcv;
  logic         acc;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;

    // ---------------- reset state ----------------
    #2;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    check("rst sticky", 32'(ovf_sticky), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rel in_ready", 32'(in_ready), 32'd1);
    tick();

    // ---------------- basic products ----------------
    run_op("1.5*2.0", 20'h01800, 20'h02000, 20'h03000, 1'b0);
    run_op("-1.5*2.0", 20'hFE800, 20'h02000, 20'hFD000, 1'b0);
    check("sticky clean", 32'(ovf_sticky), 32'd0);

    // ---------------- saturation ----------------
    run_op("100*2 sat", 20'h64000, 20'h02000, 20'h7FFFF, 1'b1);
    check("sticky set", 32'(ovf_sticky), 32'd1);
    run_op("min*min", 20'h80000, 20'h80000, 20'h7FFFF, 1'b1);
    run_op("min*1.0", 20'h80000, 20'h01000, 20'h80000, 1'b0);

    // ---------------- rounding ----------------
`ifdef FIXED_MULT_ROUND_EN
    run_op("half lsb", 20'h00800, 20'h00001, 20'h00001, 1'b0);
    run_op("neg half", 20'hFFFFF, 20'h00800, 20'h00000, 1'b0);
`else
    run_op("half lsb", 20'h00800, 20'h00001, 20'h00000, 1'b0);
    run_op("neg half", 20'hFFFFF, 20'h00800, 20'hFFFFF, 1'b0);
`endif

    // ---------------- sticky: set beats clear ----------------
    run_op("clr setup", 20'h01000, 20'h01000, 20'h01000, 1'b0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr alone", 32'(ovf_sticky), 32'd0);
    a        = 20'h80000;
    b        = 20'h80000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("clr ovf shown", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;                           // same cycle as ovf transfer
    tick();
    ovf_clr = 1'b0;
    check("set wins", 32'(ovf_sticky), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr next", 32'(ovf_sticky), 32'd0);

    // ---------------- backpressure stream ----------------
    // Operand i is (i+1).0 * 2.0, so result i is (2i+2).0.
    idx      = 0;
    rcv      = 0;
    acc      = 1'b0;
    held     = '0;
    in_valid = 1'b1;
    a        = 20'(1) << 12;
    b        = 20'h02000;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      if (acc) begin
        idx++;
        in_valid = (idx < 8);
        a        = 20'(idx + 1) << 12;
      end
      out_ready = !(cyc >= 5 && cyc < 10);
      #1;
      acc = in_valid && in_ready;
      if (cyc == 5) held = result;
      if (cyc >= 5 && cyc < 10) begin
        check("stall out_valid", 32'(out_valid), 32'd1);
        check("stall in_ready", 32'(in_ready), 32'd0);
        check("stall result", 32'(result), 32'(held));
      end
      if (out_valid && out_ready) begin
        check("stream result", 32'(result), 32'(20'(2 * (rcv + 1)) << 12));
        rcv++;
      end
      tick();
    end
    check("stream count", 32'(rcv), 32'd8);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("stream no dup", 32'(out_valid), 32'd0);
    tick();
    tick();
    check("stream idle", 32'(out_valid), 32'd0);

    // ---------------- reset with data in flight ----------------
    out_ready = 1'b0;
    a         = 20'h01800;
    b         = 20'h02000;
    in_valid  = 1'b1;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    check("flight full", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst result", 32'(result), 32'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no stale", 32'(out_valid), 32'd0);
    end
    run_op("post rst", 20'hFE800, 20'h02000, 20'hFD000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fixed_mult_pipe
